rec_player: RTL and testbench
=============================

Name: rec_player

Overview:
- Reader side of the recording store: replays a take captured by study mode.
- Fetches stored (octave, note, length) entries in order from the record memory read port.
- Issues each entry to the sound engine with a start/over handshake and inserts a fixed gap between notes.
- Drives the note LEDs and exposes the current index for the tube display; sits beside study mode under the top-level mode mux.

Parameters:
- OCT_W, 2, octave field width
- NOTE_W, 3, note field width; 0 = rest, 1..7 = do..si
- LEN_W, 3, length field width; 0 = end-of-take marker
- ADDR_W, 5, record address width (depth 2^ADDR_W)
- GAP_CYCLES, 16, idle cycles between consecutive notes (>=1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  mode enable; low forces IDLE
- start  in  1  one-cycle pulse, begin playback from address 0
- stop  in  1  one-cycle pulse, abort playback
- loop  in  1  level; restart at address 0 after the end marker or last address
- rd_en  out  1  record memory read strobe
- rd_addr  out  ADDR_W  record memory read address
- rd_data  in  OCT_W+NOTE_W+LEN_W  {octave, note, length}, valid the cycle after rd_en
- snd_start  out  1  one-cycle pulse to the sound engine
- snd_octave  out  OCT_W  held from snd_start until the next issue
- snd_note  out  NOTE_W  held, as above
- snd_length  out  LEN_W  held, as above
- snd_over  in  1  one-cycle pulse from the sound engine, note finished
- note_led  out  7  one-hot of the current note; all zero for a rest or when not playing
- cur_idx  out  ADDR_W  address of the note now sounding
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at natural end of playback

Behaviour:
- Reset and en=0 give the same result: state=IDLE and all outputs 0, including rd_addr, snd_* fields, cur_idx and note_led. en=0 mid-play aborts immediately; no snd_start and no done are emitted.
- States: IDLE, FETCH, LATCH, ISSUE, PLAY, GAP.
- IDLE:
  - start=1 and en=1: addr←0, go to FETCH.
- FETCH:
  - rd_en=1 for exactly one cycle with rd_addr=addr.
  - Go to LATCH.
- LATCH:
  - Capture rd_data.
  - If length==0 (end marker): if loop=1, set addr←0 and go to FETCH; otherwise pulse done and go to IDLE.
  - Otherwise: load snd_* fields, set cur_idx←addr, go to ISSUE.
- ISSUE:
  - snd_start=1 for one cycle.
  - Go to PLAY.
- PLAY:
  - note_led = one-hot(snd_note−1) when snd_note≠0.
  - Wait for snd_over. On snd_over: note_led←0, load the gap counter with GAP_CYCLES−1, go to GAP.
  - snd_over in any other state is ignored.
- GAP:
  - Count down to 0.
  - At 0: if addr==2^ADDR_W−1, treat it as the end marker (same loop/done rule as LATCH). Otherwise addr←addr+1 and go to FETCH.
- Latency: start to rd_en is 1 cycle; rd_en to snd_start is 2 cycles.
- Inter-note spacing: snd_over to the next snd_start is exactly GAP_CYCLES+3 cycles.
- stop=1 in any non-IDLE state: go to IDLE next cycle, clear note_led and busy. No done pulse. Takes priority over every other transition in the same cycle.
- start while busy: ignored.
- start and stop in the same cycle in IDLE: stop wins; remain IDLE.
- An empty take (entry 0 is the end marker) with loop=0: done pulses 2 cycles after start, and snd_start is never asserted.
- An empty take with loop=1 refetches address 0 indefinitely and never calls the sound engine. This is accepted behaviour; stop exits it.
- addr arithmetic is ADDR_W bits. Wrap to 0 happens only through the loop path, never silently.

Test Plan:
- Memory holds {1,3,2},{2,5,1},{0,0,0}; start, snd_over returned 10 cycles after each snd_start -> snd_start at cycle 3 with note=3, second snd_start GAP_CYCLES+3 cycles after the first snd_over with note=5, octave=2, done pulse once, busy falls.
- Same memory with loop=1 -> after the second note, rd_addr returns to 0 and note=3 is reissued; no done pulse. Stop during the second pass -> IDLE next cycle, note_led=0.
- Entry {1,0,4} (rest) -> snd_start issued, note_led stays 0 for the whole note.
- Stop asserted in the same cycle as snd_over -> IDLE, no GAP, no further rd_en.
- Full-depth take with no end marker, loop=0 -> 32 notes played, done after the 32nd gap, rd_addr never exceeds 31.
- rst_n low asynchronously during PLAY -> all outputs 0 immediately. After release, a start replays from address 0. A start pulse while busy is ignored.

Source files
------------

// File: rtl/rec_player_if.sv
// Bus bundle between the take player, the record memory read port and the
// sound engine. The player is the master: it drives the read strobe/address
// and the note fields, and receives read data and the note-finished pulse.
interface rec_player_if #(
    parameter int OCT_W  = 2,
    parameter int NOTE_W = 3,
    parameter int LEN_W  = 3,
    parameter int ADDR_W = 5
);
    // Record memory read port: data is valid the cycle after rd_en.
    logic                            rd_en;
    logic [ADDR_W-1:0]               rd_addr;
    logic [OCT_W+NOTE_W+LEN_W-1:0]   rd_data;

    // Sound engine handshake: snd_start pulse out, snd_over pulse back.
    logic                            snd_start;
    logic [OCT_W-1:0]                snd_octave;
    logic [NOTE_W-1:0]               snd_note;
    logic [LEN_W-1:0]                snd_length;
    logic                            snd_over;

    modport master (
        output rd_en,
        output rd_addr,
        input  rd_data,
        output snd_start,
        output snd_octave,
        output snd_note,
        output snd_length,
        input  snd_over
    );

    modport slave (
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  snd_start,
        input  snd_octave,
        input  snd_note,
        input  snd_length,
        output snd_over
    );
endinterface

// File: rtl/rec_player.sv
// Take player: walks the record memory from address 0, hands every stored
// (octave, note, length) entry to the sound engine, waits for it to finish,
// idles for GAP_CYCLES and moves on. A zero length, or running off the last
// address, ends the take (or restarts it when loop is high).
//
// All outputs are forced to zero combinationally while en is low so the mode
// mux sees a silent player in the very cycle the mode changes. Event outputs
// (rd_en, snd_start, done) are also suppressed in a stop cycle, because stop
// wins over whatever transition would have produced them.
module rec_player #(
    parameter int OCT_W      = 2,
    parameter int NOTE_W     = 3,
    parameter int LEN_W      = 3,
    parameter int ADDR_W     = 5,
    parameter int GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    rec_player_if.master      bus,
    output logic [6:0]        note_led,
    output logic [ADDR_W-1:0] cur_idx,
    output logic              busy,
    output logic              done
);

    // Gap counter only has to hold GAP_CYCLES-1.
    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_PLAY,
        S_GAP
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [OCT_W-1:0]    oct_q,   oct_d;
    logic [NOTE_W-1:0]   note_q,  note_d;
    logic [LEN_W-1:0]    len_q,   len_d;
    logic [ADDR_W-1:0]   idx_q,   idx_d;
    logic                done_d;

    // Fields of the entry arriving from the record memory.
    logic [OCT_W-1:0]    rd_oct;
    logic [NOTE_W-1:0]   rd_note;
    logic [LEN_W-1:0]    rd_len;

    assign {rd_oct, rd_note, rd_len} = bus.rd_data;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            oct_q   <= '0;
            note_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            oct_q   <= oct_d;
            note_q  <= note_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: en low clears everything, stop returns to IDLE, then
    // the normal fetch/latch/issue/play/gap walk.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        oct_d   = oct_q;
        note_d  = note_q;
        len_d   = len_q;
        idx_d   = idx_q;
        done_d  = 1'b0;

        if (!en) begin
            state_d = S_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
            oct_d   = '0;
            note_d  = '0;
            len_d   = '0;
            idx_d   = '0;
        end else if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_d  = '0;
                        state_d = S_FETCH;
                    end
                end

                S_FETCH: begin
                    state_d = S_LATCH;
                end

                S_LATCH: begin
                    if (rd_len == '0) begin
                        // End-of-take marker.
                        if (loop) begin
                            addr_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        oct_d   = rd_oct;
                        note_d  = rd_note;
                        len_d   = rd_len;
                        idx_d   = addr_q;
                        state_d = S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    state_d = S_PLAY;
                end

                S_PLAY: begin
                    if (bus.snd_over) begin
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end

                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (&addr_q) begin
                        // Last address played: behaves exactly like an end
                        // marker so the address never wraps on its own.
                        if (loop) begin
                            addr_d  = '0;
                            state_d = S_FETCH;
                        end else begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Memory and sound-engine side outputs, silenced while disabled.
    always_comb begin
        bus.rd_en      = en && !stop && (state_q == S_FETCH);
        bus.rd_addr    = en ? addr_q : '0;
        bus.snd_start  = en && !stop && (state_q == S_ISSUE);
        bus.snd_octave = en ? oct_q  : '0;
        bus.snd_note   = en ? note_q : '0;
        bus.snd_length = en ? len_q  : '0;
        cur_idx        = en ? idx_q  : '0;
        busy           = en && (state_q != S_IDLE);
        done           = done_d;
    end

    // One LED per note do..si; a rest (note 0) lights nothing.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_led
            assign note_led[gi] = en && (state_q == S_PLAY) &&
                                  (note_q == NOTE_W'(gi + 1));
        end
    endgenerate

endmodule

// File: tb/tb_rec_player.sv
// Bench for rec_player: a timeline model predicts every read strobe, note
// issue and done pulse of a run; a negedge monitor pops and compares them as
// the DUT produces them, checks the note LEDs each cycle and plays the sound
// engine by returning snd_over a fixed delay after each snd_start.
module tb_rec_player;

    localparam int GAP = 16;
    localparam int INF = 1 << 30;

    typedef struct {
        int cyc;
        int addr;
        int oct;
        int note;
        int len;
    } ev_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic       start = 1'b0;
    logic       stop  = 1'b0;
    logic       loop  = 1'b0;
    logic [6:0] note_led;
    logic [4:0] cur_idx;
    logic       busy;
    logic       done;

    rec_player_if #(.OCT_W(2), .NOTE_W(3), .LEN_W(3), .ADDR_W(5)) bus ();

    rec_player #(
        .OCT_W(2), .NOTE_W(3), .LEN_W(3), .ADDR_W(5), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .stop(stop),
        .loop(loop), .bus(bus), .note_led(note_led), .cur_idx(cur_idx),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record memory with one-cycle read latency.
    logic [7:0] mem [32];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int vec  = 0;
    int errs = 0;

    ev_t fq[$];
    ev_t iq[$];
    ev_t dq[$];

    int dly       = 1;
    int cut       = INF;
    int led_cut   = INF;
    int play_lo   = 0;
    int play_hi   = -1;
    int play_note = 0;
    int over_due  = -1;

    task automatic chk(input string name, input longint act, input longint exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Timeline of one run: fetch at t, data at t+1, issue at t+2, engine done
    // d cycles later, GAP idle cycles, then the next fetch. Nothing that
    // would happen at or after the abort cycle is expected.
    function automatic int model(input int c0, input int d, input bit lp, input int ct);
        int t = c0 + 1;
        int a = 0;
        int last = c0;
        ev_t e;
        logic [7:0] w;
        while (t < ct) begin
            e = '{t, a, 0, 0, 0};
            fq.push_back(e);
            last = t;
            w = mem[a];
            if (w[2:0] == 3'd0) begin
                if (lp) begin
                    a = 0;
                    t = t + 2;
                end else begin
                    if (t + 1 < ct) begin
                        e = '{t + 1, 0, 0, 0, 0};
                        dq.push_back(e);
                        last = t + 1;
                    end
                    break;
                end
            end else begin
                if (t + 2 >= ct) break;
                e = '{t + 2, a, int'(w[7:6]), int'(w[5:3]), int'(w[2:0])};
                iq.push_back(e);
                last = t + 2;
                if (t + 2 + d >= ct) break;
                t = t + 2 + d + GAP;          // last idle cycle of the gap
                if (a == 31) begin
                    if (t >= ct) break;
                    if (lp) begin
                        a = 0;
                        t = t + 1;
                    end else begin
                        e = '{t, 0, 0, 0, 0};
                        dq.push_back(e);
                        last = t;
                        break;
                    end
                end else begin
                    a = a + 1;
                    t = t + 1;
                end
            end
        end
        return last;
    endfunction

    // Monitor / scoreboard and sound-engine responder.
    always @(negedge clk) begin
        ev_t e;
        int  exp_led;
        if (bus.rd_en) begin
            if (fq.size() == 0) chk("extra_fetch", cyc, -1);
            else begin
                e = fq.pop_front();
                chk("fetch_cyc", cyc, e.cyc);
                chk("fetch_addr", bus.rd_addr, e.addr);
            end
        end
        if (bus.snd_start) begin
            if (iq.size() == 0) chk("extra_issue", cyc, -1);
            else begin
                e = iq.pop_front();
                chk("issue_cyc", cyc, e.cyc);
                chk("issue_oct", bus.snd_octave, e.oct);
                chk("issue_note", bus.snd_note, e.note);
                chk("issue_len", bus.snd_length, e.len);
                chk("issue_idx", cur_idx, e.addr);
                chk("issue_busy", busy, 1);
                play_lo   = cyc + 1;
                play_hi   = (cyc + dly < led_cut) ? cyc + dly : led_cut - 1;
                play_note = e.note;
                over_due  = cyc + dly;
            end
        end
        if (done) begin
            if (dq.size() == 0) chk("extra_done", cyc, -1);
            else begin
                e = dq.pop_front();
                chk("done_cyc", cyc, e.cyc);
            end
        end
        exp_led = (cyc >= play_lo && cyc <= play_hi && play_note != 0) ? (1 << (play_note - 1)) : 0;
        chk("note_led", note_led, exp_led);
        bus.snd_over = (cyc == over_due);
    end

    // kind: 0 natural end, 1 stop at c0+off, 2 en low at c0+off,
    //       3 async reset at c0+off, 4 start together with stop.
    task automatic run(input int d, input bit lp, input int kind, input int off, input int bs_off);
        int c0;
        int last;
        int hz;
        @(posedge clk); #1;
        c0    = cyc;
        dly   = d;
        loop  = lp;
        start = 1'b1;
        stop  = (kind == 4);
        cut     = (kind == 0) ? INF : ((kind == 4) ? c0 : c0 + off);
        led_cut = (kind == 1) ? cut + 1 : cut;
        last = model(c0, d, lp, cut);
        hz   = ((kind == 0) ? last : cut) + 4;
        while (cyc < hz) begin
            @(posedge clk); #1;
            start = (bs_off > 0 && cyc == c0 + bs_off);
            stop  = (kind == 1 && cyc == cut);
            if (kind == 2 && cyc == cut) begin
                en = 1'b0;
                #1;
                chk("en_off_busy", busy, 0);
                chk("en_off_led", note_led, 0);
                chk("en_off_idx", cur_idx, 0);
                chk("en_off_addr", bus.rd_addr, 0);
                chk("en_off_note", bus.snd_note, 0);
            end
            if (kind == 2 && cyc == cut + 2) en = 1'b1;
            if (kind == 3 && cyc == cut) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", busy, 0);
                chk("rst_led", note_led, 0);
                chk("rst_idx", cur_idx, 0);
                chk("rst_note", bus.snd_note, 0);
                chk("rst_oct", bus.snd_octave, 0);
                chk("rst_len", bus.snd_length, 0);
            end
            if (kind == 3 && cyc == cut + 2) rst_n = 1'b1;
        end
        loop = 1'b0;
        chk("fetch_left", fq.size(), 0);
        chk("issue_left", iq.size(), 0);
        chk("done_left", dq.size(), 0);
        chk("busy_end", busy, 0);
        fq.delete();
        iq.delete();
        dq.delete();
    endtask

    task automatic mem_clear();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic mem_a();
        mem_clear();
        mem[0] = {2'd1, 3'd3, 3'd2};
        mem[1] = {2'd2, 3'd5, 3'd1};
        mem[2] = {2'd0, 3'd0, 3'd0};
    endtask

    initial begin
        #12;
        chk("rst_busy0", busy, 0);
        chk("rst_led0", note_led, 0);
        chk("rst_addr0", bus.rd_addr, 0);
        chk("rst_idx0", cur_idx, 0);
        chk("rst_start0", bus.snd_start, 0);
        chk("rst_done0", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Disabled player ignores start.
        mem_a();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("disabled_busy", busy, 0);
        en = 1'b1;

        run(10, 1'b0, 0, 0, 0);          // two notes then done
        run(10, 1'b1, 1, 66, 0);         // loop, stop in second pass
        run(10, 1'b0, 1, 13, 0);         // stop together with snd_over
        run(10, 1'b0, 2, 6, 0);          // en drop mid-note
        run(10, 1'b0, 3, 6, 0);          // async reset mid-note
        run(7, 1'b0, 0, 0, 20);          // replay, start while busy ignored
        run(7, 1'b0, 4, 0, 0);           // start and stop together

        mem_clear();
        mem[0] = {2'd1, 3'd0, 3'd4};     // rest
        run(8, 1'b0, 0, 0, 0);

        mem_clear();                     // empty take
        run(5, 1'b0, 0, 0, 0);
        run(5, 1'b1, 1, 9, 0);

        for (int i = 0; i < 32; i++)     // full depth, no end marker
            mem[i] = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7))};
        run(3, 1'b0, 0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            bit lp;
            int kind;
            for (int i = 0; i < 32; i++)
                mem[i] = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(1, 7))};
            lp   = ($urandom_range(0, 3) == 0);
            kind = (lp || $urandom_range(0, 3) == 0) ? 1 : 0;
            run($urandom_range(1, 12), lp, kind, $urandom_range(2, 400), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog @cyc %0d: got timeout expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
